// File: rtl/user_core_nmi_arb_pkg.sv
// Shared types and constants for the user-core NMI arbiter slice.
package user_core_nmi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int          MAX_CORE      = 8;
   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

   // Pointer/index width for n masters; a single master still needs one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nmi_if.sv
// Native memory interface: single outstanding request, valid held until ready.
interface nmi_if;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/user_core_nmi_arb_rr_arbiter.sv
// Combinational round-robin arbiter (rr_arbiter): first request at or above ptr,
// wrapping to the bottom of the vector; one-hot grant plus binary index.
module user_core_nmi_arb_rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!any && req[j] && (j >= int'(ptr))) begin
            any = 1'b1;
            idx = PW'(j);
         end
      end
      // Second pass covers the wrap-around below the pointer.
      for (int j = 0; j < N; j++) begin
         if (!any && req[j] && (j < int'(ptr))) begin
            any = 1'b1;
            idx = PW'(j);
         end
      end
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/user_core_nmi_arb.sv
// Round-robin arbiter of NUM_CORE NMI masters onto one nmi_if.master port.
// Optional watchdog abort enabled by defining USER_CORE_NMI_ARB_TIMEOUT_EN.
module user_core_nmi_arb
   import user_core_nmi_arb_pkg::*;
#(
   parameter logic [4:0]  ID          = 5'd31,
   parameter int          NUM_CORE    = 2,
   parameter int          TIMEOUT_CYC = 1024,
   parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [31:0]                   irq_i,
   output logic [NUM_CORE-1:0][31:0]     core_irq_o,
   input  logic [NUM_CORE-1:0]           core_valid_i,
   input  logic [NUM_CORE-1:0][31:0]     core_addr_i,
   input  logic [NUM_CORE-1:0][31:0]     core_wdata_i,
   input  logic [NUM_CORE-1:0][3:0]      core_wstrb_i,
   output logic [31:0]                   core_rdata_o,
   output logic [NUM_CORE-1:0]           core_ready_o,
   nmi_if.master                         nmi,
   output logic                          err_o
);

   localparam int PW = ptr_width(NUM_CORE);

   if (NUM_CORE < 1 || NUM_CORE > MAX_CORE) begin : g_bad_num_core
      $error("user_core_nmi_arb: NUM_CORE must be in 1..8");
   end

   state_t              state;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       grant;
   logic [PW-1:0]       next_ptr;
   logic [NUM_CORE-1:0] arb_gnt;
   logic [PW-1:0]       arb_idx;
   logic                arb_any;
   logic                wd_expired;
   logic                unused_cfg;

   user_core_nmi_arb_rr_arbiter #(
      .N  (NUM_CORE),
      .PW (PW)
   ) u_rr_arbiter (
      .req (core_valid_i),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign next_ptr = (int'(grant) >= NUM_CORE - 1) ? '0 : grant + PW'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant        <= '0;
         nmi.valid    <= 1'b0;
         nmi.addr     <= '0;
         nmi.wdata    <= '0;
         nmi.wstrb    <= '0;
         core_ready_o <= '0;
         core_rdata_o <= '0;
      end else begin
         core_ready_o <= '0;
         unique case (state)
            IDLE: begin
               if (arb_any) begin
                  nmi.valid <= 1'b1;
                  nmi.addr  <= core_addr_i[arb_idx];
                  nmi.wdata <= core_wdata_i[arb_idx];
                  nmi.wstrb <= core_wstrb_i[arb_idx];
                  grant     <= arb_idx;
                  state     <= REQ;
               end
            end
            REQ: begin
               // A real response beats a watchdog expiry in the same cycle.
               if (nmi.ready || wd_expired) begin
                  nmi.valid    <= 1'b0;
                  core_rdata_o <= nmi.ready ? nmi.rdata : ERR_RDATA;
                  core_ready_o <= NUM_CORE'(1) << grant;
                  rr_ptr       <= next_ptr;
                  state        <= RESP;
               end
            end
            RESP: begin
               // Granted core drops valid on this edge; skip sampling it.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         core_irq_o <= '0;
      end else begin
         core_irq_o <= {NUM_CORE{irq_i}};
      end
   end

`ifdef USER_CORE_NMI_ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

   logic [WDW-1:0] wd_cnt;
   logic           err_q;

   assign wd_expired = (state == REQ) && !nmi.ready && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

   // Counter idles at zero outside REQ, so every REQ entry starts from zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state != REQ || nmi.ready || wd_expired) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + WDW'(1);
         end
         if (wd_expired) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o      = err_q;
   assign unused_cfg = ^ID;
`else
   assign wd_expired = 1'b0;
   assign err_o      = 1'b0;
   assign unused_cfg = ^{ID, 32'(TIMEOUT_CYC)};
`endif

endmodule

// File: doc/user_core_nmi_arb.md
Name: user_core_nmi_arb

Overview:
- Parametrised successor to the single-core user-core wrapper: hosts NUM_CORE native-memory-interface (NMI) masters and arbitrates them onto the one nmi_if.master port the SoC gives each user slot.
- Round-robin, one outstanding transaction at a time, fully registered request path.
- Optional bus-hang watchdog returns an error response so a stalled slave cannot freeze the cores.

Parameters:
- ID, 5'd31, user slot identifier; kept for top-level compatibility, unused internally.
- NUM_CORE, 2, number of upstream masters (1..8).
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a watchdog abort.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- irq_i  in  32  SoC interrupt vector.
- core_irq_o  out  NUM_CORE x 32  per-core irq, registered copy of irq_i.
- core_valid_i  in  NUM_CORE  request valid, held until matching core_ready_o.
- core_addr_i  in  NUM_CORE x 32  request address.
- core_wdata_i  in  NUM_CORE x 32  write data.
- core_wstrb_i  in  NUM_CORE x 4  byte strobes; 0 means read.
- core_rdata_o  out  32  read data, shared bus, qualified by core_ready_o.
- core_ready_o  out  NUM_CORE  one-cycle completion pulse, one-hot.
- nmi  nmi_if.master  -  downstream bus: valid, addr, wdata, wstrb out; rdata, ready in.
- err_o  out  1  sticky watchdog-abort flag (optional feature only, else tied 0).

Behaviour:
- Reset values (async, rst_n_i low):
  - nmi.valid=0, nmi.addr/wdata=0, nmi.wstrb=0.
  - core_ready_o=0, core_rdata_o=0, core_irq_o=0.
  - rr_ptr=0, state=IDLE, err_o=0, watchdog counter=0.
- State machine: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - Pick the first asserted core_valid_i scanning from rr_ptr upward, modulo NUM_CORE.
  - Latch that core's addr/wdata/wstrb into the nmi registers, set nmi.valid=1, record grant index, go to REQ.
  - Latency: nmi.valid rises 1 cycle after core_valid_i is sampled.
  - No valid asserted: stay in IDLE.
- REQ:
  - Hold nmi.valid and all request fields stable until nmi.ready=1.
  - On nmi.ready: nmi.valid<=0, core_rdata_o<=nmi.rdata, core_ready_o[grant]<=1, rr_ptr<=grant+1 (wrap to 0 at NUM_CORE), go to RESP.
- RESP:
  - core_ready_o high exactly this cycle, then cleared.
  - Next state is IDLE. The granted core drops valid on this edge, so IDLE never re-samples a stale request.
- Minimum transaction: 3 cycles from request sample to ready pulse when the slave answers in the first REQ cycle.
- Fairness: a core that has just completed has lowest priority on the next arbitration. With all cores continuously requesting, grants rotate 0,1,...,NUM_CORE-1,0.
- Non-granted cores keep valid high and wait; their requests are never modified or dropped.
- core_valid_i deasserted by a granted core mid-transaction (protocol violation): transaction still completes and the ready pulse is still issued.
- nmi.ready while not in REQ is ignored.
- NUM_CORE=1: degenerates to a registered pass-through; rr_ptr stays 0.
- core_irq_o[n] <= irq_i every cycle, 1-cycle latency, for all n.
- Reset asserted mid-transaction: immediate return to IDLE, nmi.valid=0, no ready pulse issued.

Optional Feature:
- Macro: USER_CORE_NMI_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each REQ cycle.
  - Reaching TIMEOUT_CYC-1 without nmi.ready: nmi.valid<=0, core_rdata_o<=ERR_RDATA, core_ready_o[grant] pulses, err_o<=1 (sticky until reset), rr_ptr advances, go to RESP.
  - nmi.ready in the same cycle as expiry: the normal completion wins, err_o unchanged.
- Undefined: no counter, REQ waits indefinitely, err_o tied 0.

Decomposition:
- Package user_core_nmi_arb_pkg: state enum (IDLE, REQ, RESP), ERR_RDATA default, round-robin pointer width localparam $clog2(NUM_CORE) with a minimum of 1.
- One sub-module: rr_arbiter (request vector + pointer in, one-hot grant + index out, purely combinational), reusable by other multi-master blocks.

Test Plan:
- Single core, read 0x3000_0000, slave ready after 2 cycles with rdata 0x1234_5678 -> nmi.valid high 2 cycles, core_ready_o[0] one pulse with rdata 0x1234_5678, nmi.valid low afterwards.
- NUM_CORE=4, all valid held, slave ready immediately -> grant order 0,1,2,3,0 with 3 cycles per transaction; each core's addr/wstrb appear unmodified on nmi.
- Cores 1 and 3 valid, rr_ptr=2 -> core 3 granted first, then core 1.
- Write wstrb=4'b0101, wdata 0xA5A5_5A5A -> nmi.wstrb/wdata match and stay stable through 5 stall cycles.
- TIMEOUT_EN, TIMEOUT_CYC=16, slave never ready -> after 16 REQ cycles core sees ready with 0xDEAD_BEEF, err_o=1 sticky; next core still served normally.
- Reset pulsed during REQ -> nmi.valid=0 and core_ready_o=0 on the next cycle, state IDLE, rr_ptr=0.
